// File: rtl/pkt_rr_scheduler_pkg.sv
// Shared definitions for the packet round-robin scheduler: FSM state
// encoding, the default inter-frame gap and a width helper for port indices.
package pkt_rr_scheduler_pkg;

  localparam logic [1:0] lpIDLE = 2'b00;
  localparam logic [1:0] lpREAD = 2'b01;
  localparam logic [1:0] lpGAP  = 2'b10;

  localparam int lpIFG_DEFAULT = 12;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pkt_rr_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first request at
// or after i_ptr (with wrap) as a one-hot vector, an index and a valid flag.
module rr_pick
  import pkt_rr_scheduler_pkg::*;
#(
  parameter int pN  = 4,
  parameter int pIW = idx_width(pN)
) (
  input  logic [pN-1:0]  i_req,
  input  logic [pIW-1:0] i_ptr,
  output logic [pN-1:0]  o_gnt_oh,
  output logic [pIW-1:0] o_gnt_idx,
  output logic           o_valid
);

  logic [pN-1:0]  rot;
  logic [pIW-1:0] off;
  logic [pIW:0]   sum;

  // Rotate requests so the pointer sits at bit 0, take the lowest set bit,
  // then map the offset back to an absolute port index.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_valid   = 1'b0;
    off       = '0;
    sum       = '0;
    o_gnt_idx = '0;
    o_gnt_oh  = '0;
    rot       = pN'({i_req, i_req} >> i_ptr);
    for (int k = 0; k < pN; k++) begin
      if (!o_valid && rot[k]) begin
        o_valid = 1'b1;
        off     = pIW'(k);
      end
    end
    sum = {1'b0, i_ptr} + {1'b0, off};
    if (sum >= (pIW+1)'(pN)) sum = sum - (pIW+1)'(pN);
    o_gnt_idx = sum[pIW-1:0];
    if (o_valid) o_gnt_oh = pN'(1) << o_gnt_idx;
  end

endmodule

// File: rtl/pkt_rr_scheduler.sv
// pkt_rr_scheduler: shares one transmit datapath between pPORTS packet
// buffers. Round-robin picks a buffer with a complete packet, pops its
// length, streams that many beats and then enforces an inter-frame gap.
// Optional per-port packet counters: define PKT_SCHED_STATS_EN.
module pkt_rr_scheduler
  import pkt_rr_scheduler_pkg::*;
#(
  parameter int pPORTS      = 4,
  parameter int pDATA_WIDTH = 8,
  parameter int pLEN_WIDTH  = 11,
  parameter int pIFG        = lpIFG_DEFAULT
) (
  input  logic                          iclk,
  input  logic                          i_rst,
  input  logic [pPORTS-1:0]             i_pkt_avail,
  input  logic [pPORTS*pLEN_WIDTH-1:0]  i_pkt_len,
  input  logic [pPORTS*pDATA_WIDTH-1:0] i_rx_d,
  input  logic                          i_hold,
  output logic [pPORTS-1:0]             o_len_pop,
  output logic [pPORTS-1:0]             o_rd_en,
  output logic [pDATA_WIDTH-1:0]        o_tx_d,
  output logic                          o_tx_en,
  output logic [idx_width(pPORTS)-1:0]  o_grant,
  output logic                          o_busy
`ifdef PKT_SCHED_STATS_EN
  ,
  output logic [pPORTS*16-1:0]          o_pkt_cnt
`endif
);

  localparam int lpIW = idx_width(pPORTS);
  localparam int lpGW = idx_width(pIFG);

  logic [1:0]            state;
  logic [lpIW-1:0]       rr_ptr;
  logic [lpIW-1:0]       next_ptr;
  logic [pLEN_WIDTH-1:0] rem;
  logic [lpGW-1:0]       gap_cnt;
  logic [pPORTS-1:0]     pick_oh;
  logic [lpIW-1:0]       pick_idx;
  logic                  pick_valid;
  logic                  grant_fire;
  logic [pLEN_WIDTH-1:0] pick_len;

  rr_pick #(.pN(pPORTS), .pIW(lpIW)) u_rr_pick (
    .i_req     (i_pkt_avail),
    .i_ptr     (rr_ptr),
    .o_gnt_oh  (pick_oh),
    .o_gnt_idx (pick_idx),
    .o_valid   (pick_valid)
  );

  // Strobes are gated by reset so sources never pop or advance while the
  // scheduler is being cleared.
  assign grant_fire = (state == lpIDLE) && pick_valid && !i_hold && !i_rst;
  assign pick_len   = i_pkt_len[pick_idx*pLEN_WIDTH +: pLEN_WIDTH];
  assign next_ptr   = (pick_idx == lpIW'(pPORTS-1)) ? '0 : pick_idx + 1'b1;
  assign o_busy     = (state != lpIDLE);

  // Single-cycle pop in the grant cycle and one-hot beat strobe while reading.
  always_comb begin
    o_len_pop = grant_fire ? pick_oh : '0;
    o_rd_en   = '0;
    if (state == lpREAD && !i_rst) o_rd_en = pPORTS'(1) << o_grant;
  end

  // Control FSM: grant in IDLE, count beats in READ, count idle cycles in GAP.
  always_ff @(posedge iclk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      state   <= lpIDLE;
      o_grant <= '0;
      rr_ptr  <= '0;
      rem     <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        lpIDLE: begin
          if (grant_fire) begin
            o_grant <= pick_idx;
            rr_ptr  <= next_ptr;
            rem     <= pick_len;
            state   <= (pick_len != '0) ? lpREAD : lpGAP;
          end
        end
        lpREAD: begin
          rem <= rem - 1'b1;
          if (rem == pLEN_WIDTH'(1)) state <= lpGAP;
        end
        lpGAP: begin
          if (gap_cnt == lpGW'(pIFG-1)) begin
            gap_cnt <= '0;
            state   <= lpIDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= lpIDLE;
      endcase
    end
  end

  // Registered transmit beat: the source data is valid alongside o_rd_en.
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      o_tx_en <= 1'b0;
      o_tx_d  <= '0;
    end else begin
      o_tx_en <= |o_rd_en;
      if (|o_rd_en) o_tx_d <= i_rx_d[o_grant*pDATA_WIDTH +: pDATA_WIDTH];
    end
  end

`ifdef PKT_SCHED_STATS_EN
  logic [15:0] pkt_cnt [pPORTS];

  for (genvar n = 0; n < pPORTS; n++) begin : g_stats
    // Per-port packet count, wrapping naturally at 16 bits.
    always_ff @(posedge iclk) begin
      if (i_rst)             pkt_cnt[n] <= '0;
      else if (o_len_pop[n]) pkt_cnt[n] <= pkt_cnt[n] + 16'd1;
    end
    assign o_pkt_cnt[n*16 +: 16] = pkt_cnt[n];
  end
`endif

endmodule
